// File: rtl/sfifo_rd_stream.sv
// sfifo_rd_stream: turns a registered-read FIFO port into a valid/ready stream through a 2-entry skid buffer; optional stall counter under SFIFO_RD_STREAM_STALL_CNT_EN
module sfifo_rd_stream #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef SFIFO_RD_STREAM_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);
    logic [1:0]       occ;
    logic             inflight;
    logic             pop;
    logic [2:0]       level;
    logic [WIDTH-1:0] tail;
    assign pop        = out_valid && out_ready;
    assign level      = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign fifo_rd_en = rst_n && !fifo_empty && (level < 3'd2);
    assign occupancy  = occ;
    // buffer bookkeeping: out_data is the head slot, tail holds the second word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            inflight  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            tail      <= '0;
        end else begin
            occ       <= level[1:0];
            inflight  <= fifo_rd_en;
            out_valid <= level != 3'd0;
            if (inflight && (occ == 2'd0 || (occ == 2'd1 && pop)))
                out_data <= fifo_data;
            else if (pop && occ == 2'd2)
                out_data <= tail;
            if (inflight && ((occ == 2'd1 && !pop) || occ == 2'd2))
                tail <= fifo_data;
        end
    end
`ifdef SFIFO_RD_STREAM_STALL_CNT_EN
    // count cycles where the head is offered but refused, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= 16'd0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
    // a word landing into a full buffer with no pop would be lost
    assert property (@(posedge clk) disable iff (!rst_n) !(inflight && occ == 2'd2 && !pop))
        else $error("sfifo_rd_stream: capture into full buffer");
endmodule

// File: tb/tb_sfifo_rd_stream.sv
// tb_sfifo_rd_stream: randomized and directed checks of sfifo_rd_stream against a queue-based FIFO and scoreboard
module tb_sfifo_rd_stream;
    localparam int W = 9;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_rd_en;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef SFIFO_RD_STREAM_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] fq[$];
    logic [W-1:0] got[$];
    logic         s_rd, s_valid, s_pop, s_empty, inflight_m;
    logic [W-1:0] s_data;
    logic [1:0]   s_occ;

    sfifo_rd_stream #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy)
`ifdef SFIFO_RD_STREAM_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // free-running clock
    always #5 clk = ~clk;

    // one clock cycle: sample mid-cycle, then model the FIFO's registered read port
    task automatic step();
        @(negedge clk);
        s_rd    = fifo_rd_en;
        s_valid = out_valid;
        s_data  = out_data;
        s_occ   = occupancy;
        s_empty = fifo_empty;
        s_pop   = out_valid && out_ready;
        if (s_pop) got.push_back(out_data);
        @(posedge clk);
        #1;
        if (s_rd && fq.size() > 0) fifo_data = fq.pop_front();
        fifo_empty = (fq.size() == 0);
        inflight_m = s_rd;
    endtask

    task automatic push(input logic [W-1:0] v);
        fq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        fq.delete();
        got.delete();
        fifo_empty = 1'b1;
        fifo_data = '0;
        inflight_m = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int viol = 0;
        rst_n = 1'b0;
        fifo_empty = 1'b0;
        #1;
        total++;
        if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", fifo_rd_en); end
        total++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin
            bad++; $display("FAIL reset_outputs got valid=%b occ=%0d data=%h want 0/0/0", out_valid, occupancy, out_data);
        end
`ifdef SFIFO_RD_STREAM_STALL_CNT_EN
        total++;
        if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
`endif
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_rd !== 1'b0 || s_valid !== 1'b0 || s_occ !== 2'd0) viol++;
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL idle_quiet got=%0d bad cycles want=0", viol); end
    endtask

    task automatic test_single();
        int rd_n = 0, rd_at = -1, v_n = 0, v_at = -1;
        logic [W-1:0] vd = '0;
        do_reset();
        out_ready = 1'b1;
        push(9'h1A5);
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_rd) begin rd_n++; rd_at = i; end
            if (s_valid) begin v_n++; if (v_at < 0) v_at = i; vd = s_data; end
        end
        total++;
        if (rd_n != 1) begin bad++; $display("FAIL single_rd_pulses got=%0d want=1", rd_n); end
        total++;
        if (v_at != rd_at + 2) begin bad++; $display("FAIL single_latency got=%0d want=%0d", v_at, rd_at + 2); end
        total++;
        if (v_n != 1 || vd !== 9'h1A5) begin bad++; $display("FAIL single_data got n=%0d data=%h want n=1 data=1a5", v_n, vd); end
        total++;
        if (occupancy !== 2'd0) begin bad++; $display("FAIL single_drain_occ got=%0d want=0", occupancy); end
    endtask

    task automatic test_stream();
        int rd_n = 0, first = -1, last = -1, miss = 0;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 25; k++) push(W'(k));
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_rd) rd_n++;
            if (s_pop) begin if (first < 0) first = i; last = i; end
        end
        for (int k = 0; k < 25; k++) if (k >= got.size() || got[k] !== W'(k)) miss++;
        total++;
        if (rd_n != 25) begin bad++; $display("FAIL stream_rd_count got=%0d want=25", rd_n); end
        total++;
        if (got.size() != 25 || last - first != 24) begin
            bad++; $display("FAIL stream_no_bubble got pops=%0d span=%0d want 25/24", got.size(), last - first);
        end
        total++;
        if (miss != 0) begin bad++; $display("FAIL stream_order got=%0d wrong want=0", miss); end
    endtask

    task automatic test_back_pressure();
        int guard = 0, rd_stall = 0, data_bad = 0, first = -1, last = -1, miss = 0;
        do_reset();
        for (int k = 0; k < 25; k++) push(W'(k));
        do begin step(); guard++; end while (!s_valid && guard < 10);
        total++;
        if (!s_valid) begin bad++; $display("FAIL stall_valid_rise got=0 want=1 within 10 cycles"); end
        if (s_data !== '0) data_bad++;
        for (int i = 0; i < 7; i++) begin
            step();
            if (s_rd) rd_stall++;
            if (!s_valid || s_data !== '0) data_bad++;
        end
        total++;
        if (occupancy !== 2'd2) begin bad++; $display("FAIL stall_occ got=%0d want=2", occupancy); end
        total++;
        if (rd_stall != 0) begin bad++; $display("FAIL stall_rd_low got=%0d reads want=0", rd_stall); end
        total++;
        if (data_bad != 0) begin bad++; $display("FAIL stall_data_stable got=%0d bad cycles want=0", data_bad); end
`ifdef SFIFO_RD_STREAM_STALL_CNT_EN
        total++;
        if (stall_cnt !== 16'd8) begin bad++; $display("FAIL stall_cnt got=%0d want=8", stall_cnt); end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (s_pop) begin if (first < 0) first = i; last = i; end
        end
        for (int k = 0; k < 25; k++) if (k >= got.size() || got[k] !== W'(k)) miss++;
        total++;
        if (got.size() != 25 || first != 0 || last != 24) begin
            bad++; $display("FAIL stall_release_rate got pops=%0d first=%0d last=%0d want 25/0/24", got.size(), first, last);
        end
        total++;
        if (miss != 0) begin bad++; $display("FAIL stall_order got=%0d wrong want=0", miss); end
    endtask

    task automatic test_random();
        logic [W-1:0] exp[$];
        logic [W-1:0] v, pd;
        logic pv, pp, ib, exp_rd;
        int sent = 0, guard = 0, rule_bad = 0, occ_bad = 0, stab_bad = 0, miss = 0;
        do_reset();
        pv = 1'b0; pp = 1'b0; pd = '0;
        while ((sent < 2000 || got.size() < 2000) && guard < 20000) begin
            guard++;
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 2000 && $urandom_range(0, 1) == 1) begin
                v = W'($urandom);
                push(v);
                exp.push_back(v);
                sent++;
            end
            ib = inflight_m;
            step();
            exp_rd = !s_empty && (int'(s_occ) + int'(ib) - int'(s_pop)) < 2;
            if (s_rd !== exp_rd) rule_bad++;
            if (s_occ > 2'd2 || s_valid !== (s_occ != 2'd0)) occ_bad++;
            if (pv && !pp && (!s_valid || s_data !== pd)) stab_bad++;
            pv = s_valid; pp = s_pop; pd = s_data;
        end
        for (int k = 0; k < exp.size(); k++) if (k >= got.size() || got[k] !== exp[k]) miss++;
        total++;
        if (rule_bad != 0) begin bad++; $display("FAIL rand_issue_rule got=%0d bad cycles want=0", rule_bad); end
        total++;
        if (occ_bad != 0) begin bad++; $display("FAIL rand_occ_valid got=%0d bad cycles want=0", occ_bad); end
        total++;
        if (stab_bad != 0) begin bad++; $display("FAIL rand_hold_stable got=%0d bad cycles want=0", stab_bad); end
        total++;
        if (got.size() != 2000) begin bad++; $display("FAIL rand_count got=%0d want=2000", got.size()); end
        total++;
        if (miss != 0) begin bad++; $display("FAIL rand_order got=%0d wrong want=0", miss); end
    endtask

    task automatic test_reset_mid();
        int v_n = 0;
        do_reset();
        for (int k = 0; k < 5; k++) push(W'(9'h100 + k));
        step();
        step();
        total++;
        if (occupancy !== 2'd1 || inflight_m !== 1'b1) begin
            bad++; $display("FAIL mid_setup got occ=%0d inflight=%b want 1/1", occupancy, inflight_m);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0 || fifo_rd_en !== 1'b0) begin
            bad++; $display("FAIL mid_reset_clear got valid=%b occ=%0d data=%h rd=%b want 0/0/0/0", out_valid, occupancy, out_data, fifo_rd_en);
        end
        fq.delete();
        got.delete();
        fifo_empty = 1'b1;
        inflight_m = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin step(); if (s_valid) v_n++; end
        total++;
        if (v_n != 0) begin bad++; $display("FAIL mid_no_stale got=%0d valid cycles want=0", v_n); end
        push(9'h0AB);
        for (int i = 0; i < 6; i++) step();
        total++;
        if (got.size() != 1 || got[0] !== 9'h0AB) begin
            bad++; $display("FAIL mid_after_reset got n=%0d first=%h want 1/0ab", got.size(), got.size() > 0 ? got[0] : '0);
        end
    endtask

    // run every scenario in order, then report
    initial begin
        inflight_m = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_back_pressure();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
